isa_io_target: RTL

//  ISA I/O responder: the target end of the riser's ISA I/O cycles. Decodes address_bus against a

---
 rtl/isa_io_target.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/isa_io_target.sv
// rtl/isa_io_target.sv - ISA I/O target: decoded register bank with strobe sync, iochrdy stretch and HPS access
module isa_io_target #(
    parameter logic [15:0] BASE_ADDR   = 16'h0220,
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [15:0]                 address_bus,
    input  logic [15:0]                 data_bus_in,
    input  logic                        iow,
    input  logic                        ior,
    output logic [15:0]                 data_bus_out,
    output logic                        data_oe,
    output logic                        iochrdy,
    input  logic                        hps_we,
    input  logic [$clog2(NUM_REGS)-1:0] hps_index,
    input  logic [15:0]                 hps_wdata,
    output logic [15:0]                 hps_rdata,
    output logic                        wr_event,
    output logic [$clog2(NUM_REGS)-1:0] wr_index,
    output logic                        strobe_err
);

    localparam int IW = $clog2(NUM_REGS);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [15:0]   LAST_ADDR = BASE_ADDR + 16'(NUM_REGS - 1);
    localparam logic          NO_WAIT   = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {IDLE, WAIT_W, WAIT_R, RELEASE} state_t;

    state_t          state_q, state_d;
    logic            iow_meta_q, s_iow_q, iow_prev_q;
    logic            ior_meta_q, s_ior_q, ior_prev_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [15:0]     dout_q, dout_d;
    logic            oe_q, oe_d;
    logic            rdy_q, rdy_d;
    logic            wr_event_q, wr_event_d;
    logic [IW-1:0]   wr_index_q, wr_index_d;
    logic            err_q, err_d;
    logic [15:0]     hps_rdata_q;
    logic [15:0]     bank_q [NUM_REGS];

    logic            iow_fall, ior_fall, hit, commit;
    logic [15:0]     addr_off;
    logic [IW-1:0]   idx_in;

    assign iow_fall = iow_prev_q & ~s_iow_q;
    assign ior_fall = ior_prev_q & ~s_ior_q;
    assign hit      = (address_bus >= BASE_ADDR) && (address_bus <= LAST_ADDR);
    assign addr_off = address_bus - BASE_ADDR;
    assign idx_in   = addr_off[IW-1:0];

    // Strobes idle high, so synchronisers and edge history reset to 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iow_meta_q <= 1'b1;
            s_iow_q    <= 1'b1;
            iow_prev_q <= 1'b1;
            ior_meta_q <= 1'b1;
            s_ior_q    <= 1'b1;
            ior_prev_q <= 1'b1;
        end else begin
            iow_meta_q <= iow;
            s_iow_q    <= iow_meta_q;
            iow_prev_q <= s_iow_q;
            ior_meta_q <= ior;
            s_ior_q    <= ior_meta_q;
            ior_prev_q <= s_ior_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            dout_q     <= '0;
            oe_q       <= 1'b0;
            rdy_q      <= 1'b1;
            wr_event_q <= 1'b0;
            wr_index_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            dout_q     <= dout_d;
            oe_q       <= oe_d;
            rdy_q      <= rdy_d;
            wr_event_q <= wr_event_d;
            wr_index_q <= wr_index_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        dout_d     = dout_q;
        oe_d       = oe_q;
        rdy_d      = rdy_q;
        wr_event_d = 1'b0;
        wr_index_d = wr_index_q;
        err_d      = err_q;
        commit     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!s_iow_q && !s_ior_q) begin
                    err_d = 1'b1;
                end else if (iow_fall && s_ior_q && hit) begin
                    idx_d   = idx_in;
                    wdata_d = data_bus_in;
                    cnt_d   = '0;
                    rdy_d   = NO_WAIT;
                    state_d = WAIT_W;
                end else if (ior_fall && s_iow_q && hit) begin
                    idx_d   = idx_in;
                    dout_d  = bank_q[idx_in];
                    oe_d    = 1'b1;
                    cnt_d   = '0;
                    rdy_d   = NO_WAIT;
                    state_d = WAIT_R;
                end
            end
            WAIT_W: begin
                if (NO_WAIT || cnt_q == CNT_LAST) begin
                    commit     = 1'b1;
                    wr_event_d = 1'b1;
                    wr_index_d = idx_q;
                    rdy_d      = 1'b1;
                    state_d    = RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_R: begin
                if (NO_WAIT || cnt_q == CNT_LAST) begin
                    rdy_d   = 1'b1;
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                // Wait for both strobes high so a held strobe cannot start a new cycle.
                if (s_iow_q && s_ior_q) begin
                    oe_d    = 1'b0;
                    dout_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus commit has priority over an HPS preload to the same register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                bank_q[i] <= '0;
            end
            hps_rdata_q <= '0;
        end else begin
            if (hps_we && !(commit && hps_index == idx_q)) begin
                bank_q[hps_index] <= hps_wdata;
            end
            if (commit) begin
                bank_q[idx_q] <= wdata_q;
            end
            hps_rdata_q <= bank_q[hps_index];
        end
    end

    assign data_bus_out = dout_q;
    assign data_oe      = oe_q;
    assign iochrdy      = rdy_q;
    assign hps_rdata    = hps_rdata_q;
    assign wr_event     = wr_event_q;
    assign wr_index     = wr_index_q;
    assign strobe_err   = err_q;

endmodule
